// File: rtl/cpu_pkg.sv
// Shared definitions for the sequencer: opcode values, instruction field
// positions and the control FSM state encoding.
package cpu_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned FLD_W   = 3;
  localparam int unsigned IMM_W   = 8;

  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS1_LSB = 6;
  localparam int unsigned RS2_LSB = 3;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'h8;
  localparam logic [OPC_W-1:0] OP_BZ   = 4'h9;
  localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: splits ir into register fields,
// immediate and opcode class flags.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output logic [FLD_W-1:0]   rd,
  output logic [FLD_W-1:0]   rs1,
  output logic [FLD_W-1:0]   rs2,
  output logic [IMM_W-1:0]   imm8,
  output logic [2:0]         alu_code,
  output logic               is_alu,
  output logic               is_jmp,
  output logic               is_bz,
  output logic               is_halt,
  output logic               is_illegal
);

  logic [OPC_W-1:0] opc;

  assign opc      = ir[OPC_LSB +: OPC_W];
  assign rd       = ir[RD_LSB  +: FLD_W];
  assign rs1      = ir[RS1_LSB +: FLD_W];
  assign rs2      = ir[RS2_LSB +: FLD_W];
  assign imm8     = ir[IMM_LSB +: IMM_W];
  assign alu_code = opc[2:0];

  always_comb begin
    is_alu     = 1'b0;
    is_jmp     = 1'b0;
    is_bz      = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opc)
      OP_NOP:  ;
      OP_JMP:  is_jmp  = 1'b1;
      OP_BZ:   is_bz   = 1'b1;
      OP_HALT: is_halt = 1'b1;
      // remaining codes: 0x1-0x7 are ALU ops, 0xA-0xE are undefined
      default: begin
        if (!opc[3]) is_alu     = 1'b1;
        else         is_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control sequencer: fetches 16-bit instructions, steers the
// register bank and ALU, and handles jumps, conditional branches and halt.
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [REG_AW-1:0] addr1,
  output logic [REG_AW-1:0] addr2,
  output logic [REG_AW-1:0] addrdest,
  output logic              reg_we,
  output logic [2:0]        alu_op,
  input  logic [3:0]        alu_status,
  output logic              halted,
  output logic              illegal
);

  if (DATA_W < 1) begin : g_bad_data_w
    $error("control_unit: DATA_W must be at least 1");
  end

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic               zflag;
  logic               we_q;

  logic [FLD_W-1:0]   rd, rs1, rs2;
  logic [IMM_W-1:0]   imm8;
  logic [2:0]         alu_code;
  logic               is_alu, is_jmp, is_bz, is_halt, is_illegal;
  logic               unused_status;

  instr_decode u_decode (
    .ir         (ir),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .imm8       (imm8),
    .alu_code   (alu_code),
    .is_alu     (is_alu),
    .is_jmp     (is_jmp),
    .is_bz      (is_bz),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  assign imem_addr     = pc;
  assign addr1         = REG_AW'(rs1);
  assign addr2         = REG_AW'(rs2);
  assign addrdest      = REG_AW'(rd);
  // Gating keeps the write strobe off during a freeze without losing it.
  assign reg_we        = we_q & enable;
  assign unused_status = ^alu_status[3:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= '0;
      ir       <= '0;
      zflag    <= 1'b0;
      we_q     <= 1'b0;
      imem_req <= 1'b0;
      alu_op   <= '0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
    end else if (!enable) begin
      illegal <= 1'b0;
    end else begin
      illegal <= 1'b0;
      unique case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_alu) begin
            alu_op <= alu_code;
            state  <= S_EXECUTE;
          end else if (is_halt) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            if (is_jmp || (is_bz && zflag)) pc <= PC_W'(imm8);
            else                            pc <= pc + PC_W'(1);
            illegal  <= is_illegal;
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_EXECUTE: begin
          we_q  <= 1'b1;
          state <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          we_q     <= 1'b0;
          alu_op   <= '0;
          zflag    <= alu_status[0];
          pc       <= pc + PC_W'(1);
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        S_HALT: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
